serial_addsub_unit: RTL

//   Bit-serial add/subtract engine. Sits upstream of the system's

---
 rtl/addsub_pkg.sv | 22 ++
 rtl/addsub_bit_cell.sv | 23 ++
 rtl/serial_addsub_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract engine: operation codes,
// FSM state encoding and the signed-overflow rule used for the final flags.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // For a subtraction the signs must differ to overflow; for an addition they must match.
  function automatic logic signedOverflow(input logic opV, input logic aMsb,
                                          input logic bMsb, input logic rMsb);
    logic signsAgree;
    signsAgree = (opV == OP_SUB) ? (aMsb != bMsb) : (aMsb == bMsb);
    return signsAgree && (rMsb != aMsb);
  endfunction

endpackage

// File: rtl/addsub_bit_cell.sv
// One-bit full adder / full subtractor. With op=OP_SUB it computes a-b-cin and
// cout is the borrow out; otherwise a+b+cin with cout as the carry out.
module addsub_bit_cell
  import addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic op,
  output logic s,
  output logic cout
);

  always_comb begin
    s = a ^ b ^ cin;
    if (op == OP_SUB) begin
      cout = (~a & b) | (~(a ^ b) & cin);
    end else begin
      cout = (a & b) | (cin & (a ^ b));
    end
  end

endmodule

// File: rtl/serial_addsub_unit.sv
// Bit-serial add/subtract engine: one shared bit cell walks the operands LSB
// first over WIDTH cycles, then presents the full result with a one-cycle done.
module serial_addsub_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] resSh_q, resSh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    count_q, count_d;
  logic             op_q, op_d;
  logic             aMsb_q, aMsb_d;
  logic             bMsb_q, bMsb_d;
  logic             carry_q, carry_d;
  logic             carryOut_q, carryOut_d;
  logic             overflow_q, overflow_d;

  logic             cellS;
  logic             cellCout;
  logic [WIDTH-1:0] resShifted;

  addsub_bit_cell u_cell (
    .a    (aSh_q[0]),
    .b    (bSh_q[0]),
    .cin  (carry_q),
    .op   (op_q),
    .s    (cellS),
    .cout (cellCout)
  );

  // Each new bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign resShifted = {cellS, resSh_q[WIDTH-1:1]};

  always_comb begin
    state_d    = state_q;
    aSh_d      = aSh_q;
    bSh_d      = bSh_q;
    resSh_d    = resSh_q;
    result_d   = result_q;
    count_d    = count_q;
    op_d       = op_q;
    aMsb_d     = aMsb_q;
    bMsb_d     = bMsb_q;
    carry_d    = carry_q;
    carryOut_d = carryOut_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_RUN: begin
        aSh_d   = aSh_q >> 1;
        bSh_d   = bSh_q >> 1;
        resSh_d = resShifted;
        carry_d = cellCout;
        count_d = count_q + CW'(1);
        if (count_q == LAST_BIT) begin
          state_d    = ST_DONE;
          result_d   = resShifted;
          carryOut_d = cellCout;
          overflow_d = signedOverflow(op_q, aMsb_q, bMsb_q, cellS);
        end
      end
      // IDLE, DONE and the unused encoding all accept a new operation.
      default: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_RUN;
          aSh_d   = a_in;
          bSh_d   = b_in;
          op_d    = op;
          aMsb_d  = a_in[WIDTH-1];
          bMsb_d  = b_in[WIDTH-1];
          carry_d = 1'b0;
          count_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      aSh_q      <= '0;
      bSh_q      <= '0;
      resSh_q    <= '0;
      result_q   <= '0;
      count_q    <= '0;
      op_q       <= 1'b0;
      aMsb_q     <= 1'b0;
      bMsb_q     <= 1'b0;
      carry_q    <= 1'b0;
      carryOut_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      aSh_q      <= aSh_d;
      bSh_q      <= bSh_d;
      resSh_q    <= resSh_d;
      result_q   <= result_d;
      count_q    <= count_d;
      op_q       <= op_d;
      aMsb_q     <= aMsb_d;
      bMsb_q     <= bMsb_d;
      carry_q    <= carry_d;
      carryOut_q <= carryOut_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry_out = carryOut_q;
  assign overflow  = overflow_q;

endmodule
